branch_resolve_unit: RTL

- Sits between the ID/EX pipeline stages and the 2-bit branch predictor.
- In ID it takes the predictor's taken/not-taken output for a decoded conditional branch and issues the speculative PC redirect.
- It carries that prediction one stage down to EX and compares it with the resolved outcome.
- On a mismatch it flushes and redirects the pipeline; for every resolved branch it drives the predictor's update_i/result_i, and it keeps branch and mispredict counters.

---
 rtl/branch_resolve_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch redirect and EX-stage resolution with predictor update
//
// Purpose:
//   Issues the speculative redirect for a predicted-taken conditional branch in
//   ID, carries the prediction into EX, checks it against the resolved outcome,
//   flushes and redirects on a mispredict, drives the predictor update and keeps
//   saturating branch / mispredict statistics.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          asynchronous active-low reset
//   stall_i        load-use stall: ID holds, a bubble enters EX
//   id_branch_i    conditional branch valid in ID
//   id_pc_i        PC of the ID instruction
//   id_target_i    branch target computed in ID
//   predict_i      predictor output, 1 = taken
//   ex_taken_i     resolved outcome of the EX branch
//   redirect_o     PC mux select (load redirect_pc_o next edge)
//   redirect_pc_o  next fetch PC when redirect_o=1, else 0
//   flush_if_o     squash the IF/ID register
//   flush_id_o     squash the ID/EX register
//   update_o       predictor update strobe
//   result_o       predictor training value (actual outcome)
//   branch_cnt_o   resolved branch count (saturating)
//   mispred_cnt_o  mispredicted branch count (saturating)

module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             id_branch_i,
    input  logic [PC_W-1:0]  id_pc_i,
    input  logic [PC_W-1:0]  id_target_i,
    input  logic             predict_i,
    input  logic             ex_taken_i,
    output logic             redirect_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic             flush_if_o,
    output logic             flush_id_o,
    output logic             update_o,
    output logic             result_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    // EX record
    logic             ex_valid_q,  ex_valid_d;
    logic             ex_pred_q,   ex_pred_d;
    logic [PC_W-1:0]  ex_pc4_q,    ex_pc4_d;
    logic [PC_W-1:0]  ex_target_q, ex_target_d;

    // statistics
    logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic mis;
    logic id_redirect;

    // Mispredict in EX: the resolved direction disagrees with what ID assumed.
    assign mis = ex_valid_q & (ex_taken_i != ex_pred_q);

    // ID redirect is suppressed on a stall (the branch is presented again and
    // will be redirected when it finally advances) and when EX mispredicts
    // (the ID branch is on the wrong path and is about to be squashed).
    assign id_redirect = id_branch_i & predict_i & ~stall_i & ~mis;

    // Combinational outputs
    always_comb begin
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        flush_if_o    = 1'b0;
        flush_id_o    = 1'b0;
        update_o      = ex_valid_q;
        result_o      = ex_valid_q & ex_taken_i;

        if (mis) begin
            // EX recovery wins over any ID redirect
            redirect_o    = 1'b1;
            redirect_pc_o = ex_taken_i ? ex_target_q : ex_pc4_q;
            flush_if_o    = 1'b1;
            flush_id_o    = 1'b1;
        end else if (id_redirect) begin
            redirect_o    = 1'b1;
            redirect_pc_o = id_target_i;
            flush_if_o    = 1'b1;
        end
    end

    // Next-state for the EX record
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_pred_d   = ex_pred_q;
        ex_pc4_d    = ex_pc4_q;
        ex_target_d = ex_target_q;

        if (mis || stall_i) begin
            // bubble; stale payload fields are don't-care behind ex_valid=0
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d  = id_branch_i;
            ex_pred_d   = predict_i;
            ex_pc4_d    = id_pc_i + PC_W'(4);
            ex_target_d = id_target_i;
        end
    end

    // Next-state for the saturating counters
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (ex_valid_q && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mis && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_q    <= 1'b0;
            ex_pred_q     <= 1'b0;
            ex_pc4_q      <= '0;
            ex_target_q   <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_pred_q     <= ex_pred_d;
            ex_pc4_q      <= ex_pc4_d;
            ex_target_q   <= ex_target_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule
